// File: rtl/calc_pkg.sv
// Shared types, segment constants and the digit-to-segment table.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_CONV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Active-low segment patterns, bit 0 = segment a.
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Decimal digit to active-low segments; non-decimal codes stay dark.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// One seven-segment digit: BCD value with minus and blank overrides.
module seg7_dec
    import calc_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       minus_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Blank wins over minus, minus wins over the digit value.
    always_comb begin
        seg_o = bcd_to_seg(digit_i);
        if (minus_i) seg_o = SEG_MINUS;
        if (blank_i) seg_o = SEG_BLANK;
    end

endmodule

// File: rtl/calc_bcd_seq.sv
// Switch calculator: sequential add/sub/mul/div, double-dabble to BCD,
// decimal result on active-low seven-segment digits with status LEDs.
module calc_bcd_seq
    import calc_pkg::*;
#(
    parameter int W      = 5,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2*W-1:0]      SW,
    input  logic [3:0]          KEY,
    output logic [7*DIGITS-1:0] HEX,
    output logic [3:0]          LEDR
);

    localparam int R  = 2 * W;
    localparam int CW = $clog2(R + 1);
    localparam int BW = 4 * DIGITS;

    // Largest magnitudes that fit: all digits, or all but the sign digit.
    localparam logic [31:0] MAX_POS = 32'(10 ** DIGITS - 1);
    localparam logic [31:0] MAX_NEG = 32'(10 ** (DIGITS - 1) - 1);

    localparam logic [CW-1:0] EXEC_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(R - 1);

    localparam logic [7*DIGITS-1:0] HEX_RST = {DIGITS{SEG_ZERO}};

    // Add 3 to every BCD digit >= 5 ahead of the next left shift.
    function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    logic [3:0]          key_s1_q, key_s2_q, key_s3_q;
    logic [3:0]          fall;

    state_t              state_q, state_d;
    op_t                 op_q, op_d;
    logic [R-1:0]        opa_q, opa_d;
    logic [W-1:0]        opb_q, opb_d;
    logic [W-1:0]        rem_q, rem_d;
    logic [R-1:0]        res_q, res_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                div0_q, div0_d;
    logic                ovf_q, ovf_d;
    logic                neg_led_q, neg_led_d;
    logic                div0_led_q, div0_led_d;
    logic                ovf_led_q, ovf_led_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;

    logic [W:0]          trial;
    logic                qbit;
    logic                go_conv;
    logic [BW-1:0]       bcd_adj;
    logic                dash_all;
    logic [7*DIGITS-1:0] seg_w;

    // Two-flop synchroniser plus one delay flop for press (1->0) detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_s1_q <= 4'hF;
            key_s2_q <= 4'hF;
            key_s3_q <= 4'hF;
        end else begin
            key_s1_q <= KEY;
            key_s2_q <= key_s1_q;
            key_s3_q <= key_s2_q;
        end
    end

    assign fall = key_s3_q & ~key_s2_q;

    // Next-state and datapath: operand latch, arithmetic steps, BCD shifts.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        rem_d      = rem_q;
        res_d      = res_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        div0_d     = div0_q;
        ovf_d      = ovf_q;
        neg_led_d  = neg_led_q;
        div0_led_d = div0_led_q;
        ovf_led_d  = ovf_led_q;
        hex_d      = hex_q;
        trial      = '0;
        qbit       = 1'b0;
        go_conv    = 1'b0;
        bcd_adj    = '0;

        case (state_q)
            S_IDLE: begin
                if (|fall) begin
                    if (fall[0])      op_d = OP_ADD;
                    else if (fall[1]) op_d = OP_SUB;
                    else if (fall[2]) op_d = OP_MUL;
                    else              op_d = OP_DIV;
                    opa_d   = R'(SW[2*W-1:W]);
                    opb_d   = SW[W-1:0];
                    rem_d   = '0;
                    res_d   = '0;
                    cnt_d   = '0;
                    neg_d   = 1'b0;
                    div0_d  = 1'b0;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                cnt_d = cnt_q + 1'b1;
                case (op_q)
                    OP_ADD: begin
                        res_d   = opa_q + R'(opb_q);
                        go_conv = 1'b1;
                    end
                    OP_SUB: begin
                        // Magnitude plus sign; A == B gives a non-negative zero.
                        if (opa_q >= R'(opb_q)) begin
                            res_d = opa_q - R'(opb_q);
                        end else begin
                            res_d = R'(opb_q) - opa_q;
                            neg_d = 1'b1;
                        end
                        go_conv = 1'b1;
                    end
                    OP_MUL: begin
                        if (opb_q[0]) res_d = res_q + opa_q;
                        opa_d   = opa_q << 1;
                        opb_d   = opb_q >> 1;
                        go_conv = (cnt_q == EXEC_LAST);
                    end
                    default: begin
                        // Restoring division: dividend MSB-first out of opa_q.
                        trial = {rem_q, opa_q[W-1]};
                        if (trial >= {1'b0, opb_q}) begin
                            rem_d = W'(trial - {1'b0, opb_q});
                            qbit  = 1'b1;
                        end else begin
                            rem_d = trial[W-1:0];
                        end
                        opa_d   = opa_q << 1;
                        div0_d  = (opb_q == '0);
                        res_d   = div0_d ? '0 : {res_q[R-2:0], qbit};
                        go_conv = (cnt_q == EXEC_LAST);
                    end
                endcase
                if (go_conv) begin
                    state_d = S_CONV;
                    cnt_d   = '0;
                    bcd_d   = '0;
                    ovf_d   = neg_d ? (32'(res_d) > MAX_NEG) : (32'(res_d) > MAX_POS);
                end
            end

            S_CONV: begin
                bcd_adj = dd_adjust(bcd_q);
                bcd_d   = {bcd_adj[BW-2:0], res_q[R-1]};
                res_d   = {res_q[R-2:0], 1'b0};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CONV_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end

            default: begin
                hex_d      = seg_w;
                neg_led_d  = neg_q;
                div0_led_d = div0_q;
                ovf_led_d  = ovf_q;
                state_d    = S_IDLE;
            end
        endcase
    end

    // State, operand, arithmetic, BCD and display registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_ADD;
            opa_q      <= '0;
            opb_q      <= '0;
            rem_q      <= '0;
            res_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
            neg_led_q  <= 1'b0;
            div0_led_q <= 1'b0;
            ovf_led_q  <= 1'b0;
            hex_q      <= HEX_RST;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            rem_q      <= rem_d;
            res_q      <= res_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            div0_q     <= div0_d;
            ovf_q      <= ovf_d;
            neg_led_q  <= neg_led_d;
            div0_led_q <= div0_led_d;
            ovf_led_q  <= ovf_led_d;
            hex_q      <= hex_d;
        end
    end

    assign dash_all = ovf_q | div0_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        localparam bit IS_MSD = (g == DIGITS - 1);
        seg7_dec u_dec (
            .digit_i (bcd_q[4*g +: 4]),
            .minus_i (dash_all | (IS_MSD & neg_q)),
            .blank_i (1'b0),
            .seg_o   (seg_w[7*g +: 7])
        );
    end

    assign HEX  = hex_q;
    assign LEDR = {neg_led_q, div0_led_q, ovf_led_q, (state_q != S_IDLE)};

endmodule
